// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV64I sequencer and its shared datapath:
// memory req/ready handshake, datapath enables, mux selects and status.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [2:0]  imm_sel;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [2:0]  state;

  // Controller side
  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, imm_sel, reg_write, wb_sel, trap, state
  );

  // Datapath / memory side
  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, imm_sel, reg_write, wb_sel, trap, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV64I control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB over one
// shared ALU and memory port, with a sticky TRAP for illegal opcodes and
// memory-handshake timeouts.
//
// State, instruction class, trap and the wait counter are registered. The
// datapath strobes are decoded from that registered state, because ir_write,
// pc_write and the branch decision must react to mem_ready / alu_zero in the
// same cycle. Every strobe is qualified by active_q, which clears
// asynchronously with rst, so outputs drop the moment reset is asserted and
// stay quiet for the first cycle after release.
module multicycle_ctrl #(
  parameter bit          RESET_PC_EN = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_IALU, C_RALU, C_ILL
  } class_e;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_J    = 3'd3;
  localparam logic [2:0] IMM_NONE = 3'd4;

  state_e        state_q;
  class_e        class_q;
  logic          trap_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;  // low during reset and the first cycle after release
  logic          boot_q;    // reset-vector load cycle pending

  class_e        dec_class;
  logic          run;
  logic          waiting;
  logic          timeout_hit;
  logic          br_taken;

  function automatic class_e classify(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0010011: return C_IALU;
      7'b0110011: return C_RALU;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input class_e c);
    case (c)
      C_LOAD, C_JALR, C_IALU: return IMM_I;
      C_STORE:                return IMM_S;
      C_BRANCH:               return IMM_B;
      C_JAL:                  return IMM_J;
      default:                return IMM_NONE;
    endcase
  endfunction

  assign dec_class   = classify(bus.instr[6:0]);
  assign run         = active_q & ~boot_q;
  assign waiting     = run & ~bus.mem_ready & ((state_q == S_FETCH) | (state_q == S_MEM));
  assign timeout_hit = (TIMEOUT != 0) && waiting && (cnt_q == TMO_LAST);
  // bne (funct3=001) inverts the zero flag; every other funct3 behaves as beq.
  assign br_taken    = (bus.instr[14:12] == 3'b001) ? ~bus.alu_zero : bus.alu_zero;

  // Sequencer: state, latched instruction class, sticky trap and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      class_q  <= C_ILL;
      trap_q   <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      boot_q   <= RESET_PC_EN;
    end else if (!active_q) begin
      active_q <= 1'b1;
    end else if (boot_q) begin
      boot_q <= 1'b0;
    end else begin
      cnt_q <= waiting ? cnt_q + CW'(1) : '0;
      if (timeout_hit) begin
        state_q <= S_TRAP;
        trap_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_FETCH: begin
            if (bus.mem_ready) state_q <= S_DECODE;
          end
          S_DECODE: begin
            class_q <= dec_class;
            if (dec_class == C_ILL) begin
              trap_q  <= 1'b1;
              state_q <= S_TRAP;
            end else begin
              state_q <= S_EXEC;
            end
          end
          S_EXEC: begin
            case (class_q)
              C_LOAD, C_STORE: state_q <= S_MEM;
              C_IALU, C_RALU:  state_q <= S_WB;
              default:         state_q <= S_FETCH;
            endcase
          end
          S_MEM: begin
            if (bus.mem_ready) state_q <= (class_q == C_LOAD) ? S_WB : S_FETCH;
          end
          S_WB: begin
            state_q <= S_FETCH;
          end
          S_TRAP: begin
            state_q <= S_TRAP;
          end
          default: begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  logic       mem_req_o, mem_we_o, ir_write_o, pc_write_o, alu_src_a_o, reg_write_o;
  logic [1:0] pc_src_o, alu_src_b_o, alu_op_o, wb_sel_o;
  logic [2:0] imm_sel_o;

  // Datapath strobe and select decode for the current state.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 2'd0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 2'd0;
    alu_op_o    = 2'd0;
    imm_sel_o   = IMM_NONE;
    reg_write_o = 1'b0;
    wb_sel_o    = 2'd0;
    if (active_q) begin
      if (boot_q) begin
        pc_write_o = 1'b1;
      end else begin
        case (state_q)
          S_FETCH: begin
            mem_req_o = 1'b1;
            if (bus.mem_ready) begin
              ir_write_o = 1'b1;
              pc_write_o = 1'b1;
            end
          end
          S_DECODE: begin
            imm_sel_o = imm_of(dec_class);
          end
          S_EXEC: begin
            imm_sel_o = imm_of(class_q);
            case (class_q)
              C_LOAD, C_STORE: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd1;
              end
              C_IALU: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = 2'd2;
              end
              C_RALU: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'd2;
              end
              C_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'd1;
                if (br_taken) begin
                  pc_write_o = 1'b1;
                  pc_src_o   = 2'd1;
                end
              end
              C_JAL: begin
                pc_write_o  = 1'b1;
                pc_src_o    = 2'd1;
                reg_write_o = 1'b1;
                wb_sel_o    = 2'd2;
              end
              C_JALR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd1;
                pc_write_o  = 1'b1;
                pc_src_o    = 2'd2;
                reg_write_o = 1'b1;
                wb_sel_o    = 2'd2;
              end
              default: ;
            endcase
          end
          S_MEM: begin
            // Address selects held from EXEC while the request is outstanding.
            imm_sel_o   = imm_of(class_q);
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd1;
            mem_req_o   = 1'b1;
            mem_we_o    = (class_q == C_STORE);
          end
          S_WB: begin
            imm_sel_o   = imm_of(class_q);
            reg_write_o = 1'b1;
            if (class_q == C_LOAD) begin
              wb_sel_o = 2'd1;
            end else begin
              // ALU operands held so a combinational ALU result stays valid.
              alu_src_a_o = 1'b1;
              alu_src_b_o = (class_q == C_IALU) ? 2'd1 : 2'd0;
              alu_op_o    = 2'd2;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_req   = mem_req_o;
  assign bus.mem_we    = mem_we_o;
  assign bus.ir_write  = ir_write_o;
  assign bus.pc_write  = pc_write_o;
  assign bus.pc_src    = pc_src_o;
  assign bus.alu_src_a = alu_src_a_o;
  assign bus.alu_src_b = alu_src_b_o;
  assign bus.alu_op    = alu_op_o;
  assign bus.imm_sel   = imm_sel_o;
  assign bus.reg_write = reg_write_o;
  assign bus.wb_sel    = wb_sel_o;
  assign bus.trap      = trap_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each cycle the full output word
// {state,mem_req,mem_we,ir_write,pc_write,pc_src,alu_src_a,alu_src_b,alu_op,
//  imm_sel,reg_write,wb_sel,trap} is compared with a hand-built expectation.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.RESET_PC_EN(1'b1), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [20:0] pk(input logic [2:0] st, input logic req, we, ir, pcw,
                                     input logic [1:0] pcs, input logic asa,
                                     input logic [1:0] asb, aop, input logic [2:0] imm,
                                     input logic rw, input logic [1:0] wb, input logic tr);
    return {st, req, we, ir, pcw, pcs, asa, asb, aop, imm, rw, wb, tr};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_sel, bus.reg_write,
            bus.wb_sel, bus.trap};
  endfunction

  // Leaves the DUT at a falling edge inside a normal FETCH cycle.
  task automatic reset_dut();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.instr     = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [20:0] ex [0:4];
    logic        rd [0:4];
    logic [20:0] got;
    ex = '{pk(0,0,0,0,0,0,0,0,0,4,0,0,0), pk(0,0,0,0,0,0,0,0,0,4,0,0,0),
           pk(0,0,0,0,0,0,0,0,0,4,0,0,0), pk(0,0,0,0,1,0,0,0,0,4,0,0,0),
           pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
    rd = '{1, 1, 1, 1, 0};
    rst = 1'b1;
    bus.instr = 32'h0;
    bus.alu_zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b0;
      bus.mem_ready = rd[i];
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL reset cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    $display("reset: 5 cycles checked");
  endtask

  task automatic test_alu_imm();
    logic [20:0] ex [0:4];
    logic        rd [0:4];
    logic [20:0] got;
    ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
           pk(2,0,0,0,0,0,1,1,2,0,0,0,0), pk(4,0,0,0,0,0,1,1,2,0,1,0,0),
           pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
    rd = '{1, 0, 0, 0, 0};
    bus.instr = 32'h00A00093;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rd[i];
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL addi cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    $display("addi x1,x0,10: 5 cycles checked");
  endtask

  task automatic test_alu_reg();
    logic [20:0] ex [0:4];
    logic        rd [0:4];
    logic [20:0] got;
    ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,4,0,0,0),
           pk(2,0,0,0,0,0,1,0,2,4,0,0,0), pk(4,0,0,0,0,0,1,0,2,4,1,0,0),
           pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
    rd = '{1, 0, 0, 0, 0};
    bus.instr = 32'h002081B3;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rd[i];
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL add cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    $display("add x3,x1,x2: 5 cycles checked");
  endtask

  task automatic test_load_wait();
    logic [20:0] ex [0:8];
    logic        rd [0:8];
    logic [20:0] got;
    ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
           pk(2,0,0,0,0,0,1,1,0,0,0,0,0), pk(3,1,0,0,0,0,1,1,0,0,0,0,0),
           pk(3,1,0,0,0,0,1,1,0,0,0,0,0), pk(3,1,0,0,0,0,1,1,0,0,0,0,0),
           pk(3,1,0,0,0,0,1,1,0,0,0,0,0), pk(4,0,0,0,0,0,0,0,0,0,1,1,0),
           pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
    rd = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    bus.instr = 32'h0000B103;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = rd[i];
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL ld_wait cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    $display("ld x2,0(x1) with 3 wait cycles: 9 cycles checked");
  endtask

  task automatic test_store();
    logic [20:0] ex [0:4];
    logic        rd [0:4];
    logic [20:0] got;
    ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,1,0,0,0),
           pk(2,0,0,0,0,0,1,1,0,1,0,0,0), pk(3,1,1,0,0,0,1,1,0,1,0,0,0),
           pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
    rd = '{1, 0, 0, 1, 0};
    bus.instr = 32'h0020A023;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rd[i];
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL sw cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    $display("sw x2,0(x1): 5 cycles checked");
  endtask

  task automatic test_branch();
    logic [31:0] ins  [0:3];
    logic        zero [0:3];
    logic [20:0] exe  [0:3];
    logic [20:0] ex   [0:3];
    logic [20:0] got;
    ins  = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
    zero = '{1, 0, 0, 1};
    exe  = '{pk(2,0,0,0,1,1,1,0,1,2,0,0,0), pk(2,0,0,0,0,0,1,0,1,2,0,0,0),
             pk(2,0,0,0,1,1,1,0,1,2,0,0,0), pk(2,0,0,0,0,0,1,0,1,2,0,0,0)};
    for (int k = 0; k < 4; k++) begin
      ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,2,0,0,0),
             exe[k], pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
      bus.instr    = ins[k];
      bus.alu_zero = zero[k];
      for (int i = 0; i < 4; i++) begin
        bus.mem_ready = (i == 0);
        #1;
        got = obs();
        n_vec++;
        if (got !== ex[i]) begin
          n_bad++;
          $display("FAIL branch%0d cyc%0d got=%b expected=%b", k, i, got, ex[i]);
        end
        @(negedge clk);
      end
      $display("branch instr=%h zero=%0d: 4 cycles checked", ins[k], zero[k]);
    end
    bus.alu_zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [31:0] ins [0:1];
    logic [20:0] exd [0:1];
    logic [20:0] exe [0:1];
    logic [20:0] ex  [0:3];
    logic [20:0] got;
    ins = '{32'h008000EF, 32'h000080E7};
    exd = '{pk(1,0,0,0,0,0,0,0,0,3,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0)};
    exe = '{pk(2,0,0,0,1,1,0,0,0,3,1,2,0), pk(2,0,0,0,1,2,1,1,0,0,1,2,0)};
    for (int k = 0; k < 2; k++) begin
      ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), exd[k], exe[k],
             pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
      bus.instr = ins[k];
      for (int i = 0; i < 4; i++) begin
        bus.mem_ready = (i == 0);
        #1;
        got = obs();
        n_vec++;
        if (got !== ex[i]) begin
          n_bad++;
          $display("FAIL jump%0d cyc%0d got=%b expected=%b", k, i, got, ex[i]);
        end
        @(negedge clk);
      end
      $display("jump instr=%h: 4 cycles checked", ins[k]);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] ex [0:7];
    logic [31:0] ins [0:7];
    logic [20:0] got;
    // jal immediately followed by addi, mem_ready held high throughout
    ex  = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,3,0,0,0),
            pk(2,0,0,0,1,1,0,0,0,3,1,2,0), pk(0,1,0,1,1,0,0,0,0,4,0,0,0),
            pk(1,0,0,0,0,0,0,0,0,0,0,0,0), pk(2,0,0,0,0,0,1,1,2,0,0,0,0),
            pk(4,0,0,0,0,0,1,1,2,0,1,0,0), pk(0,1,0,1,1,0,0,0,0,4,0,0,0)};
    ins = '{32'h008000EF, 32'h008000EF, 32'h008000EF, 32'h00A00093,
            32'h00A00093, 32'h00A00093, 32'h00A00093, 32'h00A00093};
    for (int i = 0; i < 8; i++) begin
      bus.instr = ins[i];
      bus.mem_ready = (i != 7) ? 1'b1 : 1'b1;
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL b2b cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      if (i == 7) bus.mem_ready = 1'b0;
      @(negedge clk);
    end
    $display("back-to-back jal+addi: 8 cycles checked");
  endtask

  task automatic test_illegal();
    logic [20:0] ex [0:4];
    logic [20:0] got;
    ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,4,0,0,0),
           pk(5,0,0,0,0,0,0,0,0,4,0,0,1), pk(5,0,0,0,0,0,0,0,0,4,0,0,1),
           pk(5,0,0,0,0,0,0,0,0,4,0,0,1)};
    bus.instr = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = 1'b1;
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL illegal cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    got = obs();
    n_vec++;
    if (got !== pk(0,0,0,0,0,0,0,0,0,4,0,0,0)) begin
      n_bad++;
      $display("FAIL illegal_rst got=%b expected=%b", got, pk(0,0,0,0,0,0,0,0,0,4,0,0,0));
    end
    reset_dut();
    $display("illegal opcode ffffffff: 6 cycles checked");
  endtask

  task automatic test_timeout();
    logic [20:0] ex [0:5];
    logic [20:0] got;
    ex = '{pk(0,1,0,0,0,0,0,0,0,4,0,0,0), pk(0,1,0,0,0,0,0,0,0,4,0,0,0),
           pk(0,1,0,0,0,0,0,0,0,4,0,0,0), pk(0,1,0,0,0,0,0,0,0,4,0,0,0),
           pk(5,0,0,0,0,0,0,0,0,4,0,0,1), pk(5,0,0,0,0,0,0,0,0,4,0,0,1)};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL timeout cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    reset_dut();
    $display("fetch timeout (TIMEOUT=4): 6 cycles checked");
  endtask

  task automatic test_reset_mid_mem();
    logic [20:0] ex [0:7];
    logic        rd [0:7];
    logic [20:0] got;
    ex = '{pk(0,1,0,1,1,0,0,0,0,4,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
           pk(2,0,0,0,0,0,1,1,0,0,0,0,0), pk(3,1,0,0,0,0,1,1,0,0,0,0,0),
           pk(0,0,0,0,0,0,0,0,0,4,0,0,0), pk(0,0,0,0,0,0,0,0,0,4,0,0,0),
           pk(0,0,0,0,1,0,0,0,0,4,0,0,0), pk(0,1,0,0,0,0,0,0,0,4,0,0,0)};
    rd = '{1, 0, 0, 0, 1, 1, 1, 0};
    bus.instr = 32'h0000B103;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rd[i];
      if (i == 4) rst = 1'b1;
      if (i == 5) rst = 1'b0;
      #1;
      got = obs();
      n_vec++;
      if (got !== ex[i]) begin
        n_bad++;
        $display("FAIL rst_mid_mem cyc%0d got=%b expected=%b", i, got, ex[i]);
      end
      @(negedge clk);
    end
    $display("rst during MEM of ld: 8 cycles checked");
  endtask

  initial begin
    rst = 1'b1;
    bus.instr = 32'h0;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_imm();
    test_alu_reg();
    test_load_wait();
    test_store();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM that sequences a shared datapath (one ALU, one memory port, register file, immediate generator) over several cycles per RV64I instruction. It holds the opcode, decodes instruction class, and drives every datapath enable and mux select cycle by cycle. The memory port uses a req/ready handshake. It also drives the immediate-format select that feeds the immediate generator.

Parameters:
RESET_PC_EN, 1, when 1 assert pc_write for one cycle after reset release to load the reset vector
TIMEOUT, 255, max cycles to wait for mem_ready before entering TRAP; 0 disables the timeout

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
instr  input  32  instruction register contents (valid from DECODE onward)
alu_zero  input  1  ALU zero flag (branch compare)
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request valid
mem_we  output  1  request is a write (store)
ir_write  output  1  latch fetched word into instruction register
pc_write  output  1  update PC
pc_src  output  2  0=PC+4, 1=branch/jal target, 2=jalr target (ALU result & ~1)
alu_src_a  output  1  0=PC, 1=rs1
alu_src_b  output  2  0=rs2, 1=imm, 2=constant 4
alu_op  output  2  0=add, 1=subtract (branch), 2=funct-decoded
imm_sel  output  3  0=I, 1=S, 2=B, 3=J, 4=none
reg_write  output  1  register file write enable
wb_sel  output  2  0=ALU result, 1=memory data, 2=PC+4
trap  output  1  illegal opcode or memory timeout; sticky until reset
state  output  3  current state, for debug

Behaviour:
- Reset (async): state=FETCH, all outputs 0 except imm_sel=4; trap=0; timeout counter=0. Release is synchronous to clk.
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), TRAP(5).
- FETCH: mem_req=1, mem_we=0. When mem_ready=1 the same cycle: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE: register classifies instr[6:0]:
  - 0000011 load
  - 0100011 store
  - 1100011 branch
  - 1101111 jal
  - 1100111 jalr
  - 0010011 I-ALU
  - 0110011 R-ALU
  - any other opcode: trap=1, go to TRAP.
  - imm_sel is driven from DECODE through the last state of the instruction: I for load/jalr/I-ALU, S for store, B for branch, J for jal, none for R-ALU.
- EXEC:
  - load/store: alu_src_a=1, alu_src_b=1, alu_op=0, then MEM.
  - I-ALU: alu_src_a=1, alu_src_b=1, alu_op=2, then WB.
  - R-ALU: alu_src_a=1, alu_src_b=0, alu_op=2, then WB.
  - branch: alu_src_a=1, alu_src_b=0, alu_op=1. If alu_zero=1: pc_write=1, pc_src=1. Then FETCH.
  - jal: pc_write=1, pc_src=1, reg_write=1, wb_sel=2, then FETCH.
  - jalr: alu_src_a=1, alu_src_b=1, alu_op=0, pc_write=1, pc_src=2, reg_write=1, wb_sel=2, then FETCH.
  - Branch decision: only funct3=000 (beq) is required; other funct3 values use zero-flag inverse for 001 and are treated as beq otherwise.
- MEM: mem_req=1, mem_we=1 for store. Hold the address selects from EXEC. When mem_ready=1: store goes to FETCH, load goes to WB.
- WB: reg_write=1 for exactly one cycle; wb_sel=1 for load, 0 for ALU ops; then FETCH.
- Per-instruction cycle counts with mem_ready always 1:
  - load 5 cycles
  - store 4 cycles
  - ALU ops 4 cycles
  - branch, jal, jalr 3 cycles
- Timeout: a counter increments each cycle spent in FETCH/MEM with mem_ready=0 and clears on leaving the state. When the count reaches TIMEOUT (TIMEOUT≠0): trap=1, go to TRAP, mem_req drops the next cycle.
- TRAP: all enables 0, mem_req=0; stays until rst.
- mem_req stays asserted and mem_we stays stable until mem_ready; no request is withdrawn early except on timeout or rst.
- reg_write, pc_write and ir_write are never asserted in TRAP or during reset.
- rst mid-instruction aborts immediately; no partial writeback occurs after reset release.

Test Plan:
- Reset, then mem_ready=1, instr=0x00A00093 (addi x1,x0,10) -> states 0,1,2,4,0; reg_write=1 only in cycle 4; imm_sel=0; alu_src_b=1.
- instr=0x0000B103 (ld) with mem_ready low 3 cycles in MEM -> stays in MEM 4 cycles with mem_req=1, mem_we=0; then WB with wb_sel=1; 8 cycles total.
- instr=0x00208463 (beq): alu_zero=1 -> pc_write=1, pc_src=1 in EXEC. alu_zero=0 -> pc_write=0. imm_sel=2 in both cases.
- instr=0x008000EF (jal): EXEC asserts pc_write, pc_src=1, reg_write, wb_sel=2, imm_sel=3; back to FETCH after 3 cycles.
- instr=0xFFFFFFFF -> trap=1 after DECODE; state=5; no enables thereafter; rst clears it to FETCH.
- mem_ready held 0 in FETCH with TIMEOUT=4 -> trap asserts after 4 waiting cycles. Separately, rst asserted mid-MEM -> async return to FETCH, outputs zeroed the same cycle.
